mem_indirect_seq: RTL

MEM_INDIRECT_SEQ -- requirements
Module: mem_indirect_seq

---
 rtl/lc3b_types.sv | 28 ++
 rtl/mem_indirect_seq_if.sv | 30 +++
 rtl/mem_indirect_ptr_reg.sv | 49 ++++
 rtl/mem_indirect_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// LC-3b shared types: opcodes, indirect memory sequencer states and the
// legal LEVELS range for mem_indirect_seq.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'h0, op_add, op_ldb, op_stb, op_jsr, op_and, op_ldr, op_str,
    op_rti, op_not, op_ldi, op_sti, op_jmp, op_shf, op_lea, op_trap
  } lc3b_opcode;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PTR,
    S_FINAL,
    S_DONE
  } mem_ind_state_e;

  localparam int MEM_IND_LEVELS_MIN = 1;
  localparam int MEM_IND_LEVELS_MAX = 4;

  function automatic bit is_indirect(lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

  function automatic bit levels_in_range(int levels);
    return (levels >= MEM_IND_LEVELS_MIN) && (levels <= MEM_IND_LEVELS_MAX);
  endfunction

endpackage

// File: rtl/mem_indirect_seq_if.sv
// Pipeline/memory bundle of the indirect sequencer; master is the sequencer,
// slave is the pipeline plus memory side.
interface mem_indirect_seq_if #(parameter int WIDTH = 16);
  import lc3b_types::*;

  lc3b_opcode       opcode;
  logic             flush;
  logic [WIDTH-1:0] base_addr;
  logic [WIDTH-1:0] store_data;
  logic             mem_resp;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] mem_wdata;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] load_data;

  modport master (
    input  opcode, flush, base_addr, store_data, mem_resp, mem_rdata,
    output mem_addr, mem_read, mem_write, mem_wdata, stall, done, load_data
  );

  modport slave (
    output opcode, flush, base_addr, store_data, mem_resp, mem_rdata,
    input  mem_addr, mem_read, mem_write, mem_wdata, stall, done, load_data
  );

endinterface

// File: rtl/mem_indirect_ptr_reg.sv
// Pointer register and dereference level counter of the indirect sequencer.
// The counter saturates at LEVELS so it can never wrap.
module mem_indirect_ptr_reg #(
  parameter int WIDTH  = 16,
  parameter int LEVELS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_base,
  input  logic             advance,
  input  logic [WIDTH-1:0] base_addr,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] ptr,
  output logic             last_level
);

  localparam int CW = $clog2(LEVELS + 1);

  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    level_q, level_d;

  always_comb begin
    ptr_d   = ptr_q;
    level_d = level_q;
    if (load_base) begin
      ptr_d   = base_addr;
      level_d = '0;
    end else if (advance) begin
      ptr_d = rdata;
      if (level_q != CW'(LEVELS)) level_d = level_q + CW'(1);
    end
  end

  // NOTE: state flops take non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      level_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      level_q <= level_d;
    end
  end

  assign ptr        = ptr_q;
  assign last_level = (level_q == CW'(LEVELS - 1));

endmodule

// File: rtl/mem_indirect_seq.sv
// LDI/STI indirect memory sequencer: LEVELS pointer reads, then the final
// read or write. Optional wait timeout under MEM_INDIRECT_TIMEOUT_EN.
module mem_indirect_seq
  import lc3b_types::*;
#(
  parameter int WIDTH  = 16,
  parameter int LEVELS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_indirect_seq_if.master  bus
`ifdef MEM_INDIRECT_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  if (!levels_in_range(LEVELS)) begin : g_bad_levels
    $error("mem_indirect_seq: LEVELS must be within 1..4");
  end

  mem_ind_state_e   state_q, state_d;
  logic             is_sti_q, is_sti_d;
  logic [WIDTH-1:0] load_data_q, load_data_d;
  logic [WIDTH-1:0] ptr;
  logic             start, busy, load_base, advance, last_level, timeout_hit;

  assign start = is_indirect(bus.opcode) && !bus.flush;
  assign busy  = (state_q == S_PTR) || (state_q == S_FINAL);

`ifdef MEM_INDIRECT_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;

  assign timeout_hit = busy && !bus.mem_resp && (wait_q == 8'hFF);

  always_comb begin
    wait_d = '0;
    if (busy && !bus.mem_resp && !timeout_hit) wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end

  assign timeout_err = rst_n && timeout_hit;
`else
  assign timeout_hit = 1'b0;
`endif

  mem_indirect_ptr_reg #(.WIDTH(WIDTH), .LEVELS(LEVELS)) u_ptr_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_base (load_base),
    .advance   (advance),
    .base_addr (bus.base_addr),
    .rdata     (bus.mem_rdata),
    .ptr       (ptr),
    .last_level(last_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_sti_q    <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      is_sti_q    <= is_sti_d;
      load_data_q <= load_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_sti_d    = is_sti_q;
    load_data_d = load_data_q;
    load_base   = 1'b0;
    advance     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PTR;
          load_base = 1'b1;
          is_sti_d  = (bus.opcode == op_sti);
        end
      end
      S_PTR: begin
        if (bus.mem_resp) begin
          advance = 1'b1;
          if (last_level) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        if (bus.mem_resp) begin
          if (!is_sti_q) load_data_d = bus.mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
    // A completing response still lands; flush or timeout only suppress DONE.
    if (busy && (bus.flush || timeout_hit)) state_d = S_IDLE;
  end

  // NOTE: every output is given a default before the case so no latch is
  // inferred for paths that do not assign it.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wdata = '0;
    bus.stall     = 1'b0;
    bus.done      = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_IDLE: bus.stall = start;
        S_PTR: begin
          bus.mem_read = 1'b1;
          bus.mem_addr = ptr;
          bus.stall    = 1'b1;
        end
        S_FINAL: begin
          bus.mem_addr = ptr;
          bus.stall    = 1'b1;
          if (is_sti_q) begin
            bus.mem_write = 1'b1;
            bus.mem_wdata = bus.store_data;
          end else begin
            bus.mem_read = 1'b1;
          end
        end
        S_DONE: bus.done = 1'b1;
      endcase
    end
  end

  assign bus.load_data = load_data_q;

endmodule
